// File: rtl/inst_loader_if.sv
// Instruction loader bus: word stream in (valid/ready) plus the
// instruction-memory write port out.
// Handshake: a word transfers on a rising edge where word_valid and
// word_ready are both high; word_ready never depends on word_valid, and
// word_in/word_last are only meaningful while word_valid is high.
interface inst_loader_if #(
    parameter int A = 4,
    parameter int W = 9
);
    logic         word_valid;
    logic         word_ready;
    logic [W-1:0] word_in;
    logic         word_last;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;

    // Loader side: consumes words, drives the memory write port.
    modport slave (
        input  word_valid, word_in, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );

    // Host side: produces words, observes the memory write port.
    modport master (
        output word_valid, word_in, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: writes a stream of instruction words into instruction memory
// at consecutive addresses from 0, holding the fetch unit in reset for the
// whole session and releasing it once the program is in place.
// Optional feature macro INST_LOADER_CHECKSUM_EN: after the last program word
// one extra checksum word (XOR of all program words) must arrive; a mismatch
// ends the session in ERR instead of DONE.
module inst_loader #(
    parameter int A = 4,
    parameter int W = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    inst_loader_if.slave  bus,
    output logic          core_reset,
    output logic          load_done,
    output logic          load_err,
    output logic [A:0]    words_loaded,
    output logic [2:0]    dbg_state
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4,
        S_CHECK   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;
`endif

    state_t       state;
    state_t       state_next;
    logic [A-1:0] counter;
    logic         write_accept;
    logic         start;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [W-1:0] acc;
`endif

    // Only program words in LOAD are written; a checksum word in CHECK is not.
    assign write_accept = (state == S_LOAD) && bus.word_valid;
    assign start        = load_req &&
                          ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next     = state;
        bus.word_ready = 1'b0;
        core_reset     = 1'b1;
        load_done      = 1'b0;
        load_err       = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_req) state_next = S_LOAD;
            end
            S_LOAD: begin
                bus.word_ready = 1'b1;
                if (bus.word_valid) begin
                    if (bus.word_last) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_next = S_CHECK;
`else
                        state_next = S_RELEASE;
`endif
                    end else if (counter == {A{1'b1}}) begin
                        // Memory full and more words promised: no wrap to 0.
                        state_next = S_ERR;
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHECK: begin
                bus.word_ready = 1'b1;
                if (bus.word_valid) begin
                    state_next = (bus.word_in == acc) ? S_RELEASE : S_ERR;
                end
            end
`endif
            S_RELEASE: begin
                // One more reset cycle so the final write lands before fetch runs.
                state_next = S_DONE;
            end
            S_DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
                if (load_req) state_next = S_LOAD;
            end
            S_ERR: begin
                load_err = 1'b1;
                if (load_req) state_next = S_LOAD;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Write port, address counter, word count (and checksum accumulator).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            counter       <= '0;
            words_loaded  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            acc           <= '0;
`endif
        end else begin
            bus.mem_we <= write_accept;
            if (write_accept) begin
                bus.mem_addr  <= counter;
                bus.mem_wdata <= bus.word_in;
                counter       <= counter + 1'b1;
                words_loaded  <= words_loaded + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                acc           <= acc ^ bus.word_in;
`endif
            end
            if (start) begin
                counter      <= '0;
                words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                acc          <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed session sequence, memory writes checked
// against a queue of expected {addr, data} pairs.
// Honours INST_LOADER_CHECKSUM_EN the same way as the design.
module tb_inst_loader;
    localparam int A = 4;
    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         load_req;
    logic         core_reset;
    logic         load_done;
    logic         load_err;
    logic [A:0]   words_loaded;
    logic [2:0]   dbg_state;

    inst_loader_if #(.A(A), .W(W)) ifc ();

    inst_loader #(.A(A), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .bus          (ifc.slave),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

    int unsigned      n_checks = 0;
    int unsigned      n_fail   = 0;
    int unsigned      n_writes = 0;
    logic [A+W-1:0]   exp_q[$];
    logic [A-1:0]     exp_addr;
    logic [W-1:0]     acc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && ifc.mem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {ifc.mem_addr, ifc.mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                chk("mem_write", {ifc.mem_addr, ifc.mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // Pulse load_req for one cycle; optionally with word_valid in the same cycle.
    task automatic start_load(input bit with_word);
        load_req = 1'b1;
        if (with_word) begin
            ifc.word_valid = 1'b1;
            ifc.word_in    = 9'h1FF;
            ifc.word_last  = 1'b1;
        end
        step();
        load_req       = 1'b0;
        ifc.word_valid = 1'b0;
        ifc.word_last  = 1'b0;
        exp_addr       = '0;
        acc_m          = '0;
        chk("load_ready", ifc.word_ready, 1);
        chk("load_core_reset", core_reset, 1);
        chk("load_count_clr", words_loaded, 0);
    endtask

    // Offer one word after 'gap' idle cycles and wait (bounded) for acceptance.
    task automatic send_word(input logic [W-1:0] d, input logic last, input int gap,
                             input bit is_data);
        int budget;
        logic [A-1:0] a;
        ifc.word_valid = 1'b0;
        repeat (gap) step();
        ifc.word_valid = 1'b1;
        ifc.word_in    = d;
        ifc.word_last  = last;
        budget = 0;
        while (ifc.word_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        chk("accept_timeout", (budget < 20) ? 1 : 0, 1);
        if (budget < 20) begin
            a = exp_addr;
            if (is_data) begin
                exp_q.push_back({a, d});
                exp_addr = exp_addr + 1'b1;
                acc_m    = acc_m ^ d;
            end
            step();
            ifc.word_valid = 1'b0;
            ifc.word_last  = 1'b0;
            if (is_data) begin
                chk("write_latency_we", ifc.mem_we, 1);
                chk("write_latency_addr", ifc.mem_addr, a);
            end else begin
                chk("cksum_not_written", ifc.mem_we, 0);
            end
        end
        ifc.word_valid = 1'b0;
    endtask

    // After the last program word: send the checksum when that feature is built in.
    task automatic end_program();
`ifdef INST_LOADER_CHECKSUM_EN
        send_word(acc_m, 1'b0, 0, 1'b0);
`endif
    endtask

    // Expect RELEASE now, then DONE on the next cycle with the given count.
    task automatic expect_release_done(input int n);
        chk("rel_core_reset", core_reset, 1);
        chk("rel_ready", ifc.word_ready, 0);
        chk("rel_done", load_done, 0);
        step();
        chk("done_core_reset", core_reset, 0);
        chk("done_flag", load_done, 1);
        chk("done_err", load_err, 0);
        chk("done_count", words_loaded, n);
    endtask

    initial begin
        int w0;
        logic [W-1:0] d;
        reset          = 1'b1;
        load_req       = 1'b0;
        ifc.word_valid = 1'b0;
        ifc.word_in    = '0;
        ifc.word_last  = 1'b0;
        exp_addr       = '0;
        acc_m          = '0;
        #1;
        // Reset values.
        chk("rst_core_reset", core_reset, 1);
        chk("rst_ready", ifc.word_ready, 0);
        chk("rst_we", ifc.mem_we, 0);
        chk("rst_addr", ifc.mem_addr, 0);
        chk("rst_wdata", ifc.mem_wdata, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_count", words_loaded, 0);
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("idle_core_reset", core_reset, 1);
        chk("idle_ready", ifc.word_ready, 0);
        chk("idle_no_writes", n_writes, 0);

        // Session 1: load_req with a word in the same IDLE cycle, then 1,2,3.
        start_load(1'b1);
        chk("idle_word_ignored", ifc.mem_we, 0);
        send_word(9'd1, 1'b0, 0, 1'b1);
        send_word(9'd2, 1'b0, 0, 1'b1);
        send_word(9'd3, 1'b1, 0, 1'b1);
        end_program();
        expect_release_done(3);

        // Words offered in DONE are not taken.
        ifc.word_valid = 1'b1;
        ifc.word_in    = 9'h0AA;
        step();
        chk("done_not_ready", ifc.word_ready, 0);
        step();
        ifc.word_valid = 1'b0;
        chk("done_stays", load_done, 1);

        // Session 2: same program with 2-cycle gaps.
        w0 = n_writes;
        start_load(1'b0);
        send_word(9'd1, 1'b0, 2, 1'b1);
        send_word(9'd2, 1'b0, 2, 1'b1);
        send_word(9'd3, 1'b1, 2, 1'b1);
        end_program();
        expect_release_done(3);
        chk("gap_write_count", n_writes - w0, 3);

        // Session 3: full memory, last on the 16th word.
        start_load(1'b0);
        for (int i = 0; i < 16; i++) begin
            d = W'($urandom_range(0, 511));
            send_word(d, (i == 15) ? 1'b1 : 1'b0, $urandom_range(0, 1), 1'b1);
        end
        end_program();
        expect_release_done(16);

        // Session 4: 16 words without last -> overflow into ERR.
        w0 = n_writes;
        start_load(1'b0);
        for (int i = 0; i < 16; i++) begin
            send_word(W'($urandom_range(0, 511)), 1'b0, 0, 1'b1);
        end
        chk("ovf_err", load_err, 1);
        chk("ovf_core_reset", core_reset, 1);
        chk("ovf_ready", ifc.word_ready, 0);
        chk("ovf_count", words_loaded, 16);
        ifc.word_valid = 1'b1;
        ifc.word_in    = 9'h155;
        repeat (3) step();
        ifc.word_valid = 1'b0;
        chk("ovf_err_hold", load_err, 1);
        chk("ovf_write_count", n_writes - w0, 16);

        // Session 5: reset after two accepted words aborts at once.
        start_load(1'b0);
        send_word(9'd7, 1'b0, 0, 1'b1);
        send_word(9'd8, 1'b0, 0, 1'b1);
        step();
        ifc.word_valid = 1'b1;
        ifc.word_in    = 9'd9;
        #2;
        reset = 1'b1;
        #1;
        chk("abort_core_reset", core_reset, 1);
        chk("abort_ready", ifc.word_ready, 0);
        chk("abort_we", ifc.mem_we, 0);
        chk("abort_count", words_loaded, 0);
        chk("abort_state", dbg_state, 0);
        ifc.word_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        start_load(1'b0);
        send_word(9'd9, 1'b1, 0, 1'b1);
        end_program();
        expect_release_done(1);

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        w0 = n_writes;
        start_load(1'b0);
        send_word(9'd5, 1'b0, 0, 1'b1);
        send_word(9'd3, 1'b1, 0, 1'b1);
        send_word(9'd6, 1'b0, 0, 1'b0);
        expect_release_done(2);
        start_load(1'b0);
        send_word(9'd5, 1'b0, 0, 1'b1);
        send_word(9'd3, 1'b1, 0, 1'b1);
        send_word(9'd7, 1'b0, 0, 1'b0);
        chk("cksum_bad_err", load_err, 1);
        chk("cksum_bad_core_reset", core_reset, 1);
        step();
        chk("cksum_write_count", n_writes - w0, 4);
`endif

        step();
        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction memory: accepts a stream of 9-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive addresses from 0.
- Drives the fetch unit's reset for the whole load session, then releases it so fetch starts at address 0 on the freshly loaded program.
- Sits between the host/bench stimulus and the instruction memory write port, alongside the fetch unit.

Parameters:
- A, 4, instruction address width; memory depth 2^A words.
- W, 9, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  single-cycle request to start a load session; honoured only in IDLE, DONE or ERR.
- word_valid  input  1  word_in and word_last are valid this cycle.
- word_in  input  W  instruction word.
- word_last  input  1  marks the final program word.
- word_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  A  instruction memory write address.
- mem_wdata  output  W  instruction memory write data.
- core_reset  output  1  drives the fetch unit's reset input.
- load_done  output  1  level; high while in DONE.
- load_err  output  1  level; high while in ERR.
- words_loaded  output  A+1  count of words written in the current or last session.

Behaviour:
- Reset values (async, immediate): state IDLE, word_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_reset 1, load_done 0, load_err 0, words_loaded 0, address counter 0.
- States: IDLE, LOAD, RELEASE, DONE, ERR (plus CHECK under the optional feature).
- IDLE:
  - core_reset=1, word_ready=0.
  - load_req -> LOAD; clear address counter and words_loaded.
- LOAD:
  - word_ready=1, combinational from state only and never dependent on word_valid. core_reset=1.
  - Accept = word_valid & word_ready.
  - On accept, next cycle: mem_we=1, mem_addr=counter, mem_wdata=word_in; counter+1; words_loaded+1. Write latency is exactly 1 cycle.
  - mem_we is 0 in every cycle not following an accept.
  - Accept with word_last=1 -> RELEASE.
  - Accept with word_last=0 at counter=2^A-1: the word is written, then -> ERR (overflow; no wrap to address 0).
  - load_req in LOAD is ignored.
- RELEASE:
  - core_reset=1 for exactly this one cycle, covering the final write. word_ready=0.
  - Unconditionally -> DONE.
- DONE:
  - core_reset=0, load_done=1, word_ready=0.
  - load_req -> LOAD, starting a new session; core_reset=1 in the next cycle.
- ERR:
  - core_reset=1, load_err=1, word_ready=0.
  - Exits only via load_req -> LOAD.
- Boundaries:
  - Program of exactly 2^A words with word_last on the last word -> DONE; words_loaded=2^A, hence the A+1 width.
  - word_valid in IDLE/RELEASE/DONE/ERR is not accepted and has no effect.
  - reset mid-LOAD aborts immediately; already-written memory words are not cleared; core_reset=1.
  - load_req and word_valid in the same IDLE cycle: only the state change happens; no word is accepted that cycle.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - An XOR accumulator (W bits, cleared on load_req) folds in every accepted program word.
  - The word_last accept goes to CHECK instead of RELEASE.
  - In CHECK, word_ready=1 and core_reset=1; the next accepted word is a checksum, not written and not counted.
  - Checksum equal to accumulator -> RELEASE; mismatch -> ERR.
  - Overflow rule unchanged.
- Undefined: no accumulator and no CHECK state; word_last goes straight to RELEASE.

Test Plan:
- reset=1, then 0 with no load_req -> core_reset=1, word_ready=0, mem_we never asserted.
- load_req; words 9'b000000001, 9'b000000010, 9'b000000011 (last on third) with word_valid continuous -> writes addr0=1, addr1=2, addr2=3, each 1 cycle after accept; RELEASE 1 cycle; DONE with core_reset=0; words_loaded=3.
- Same stream with word_valid gaps of 2 idle cycles between words -> identical memory contents; mem_we asserted only 3 cycles total.
- A=4: 16 words, word_last on the 16th -> DONE, words_loaded=16. Repeat with no word_last -> 16 writes, then ERR, load_err=1, core_reset=1, no write to addr0 after addr15.
- reset asserted after 2 of 3 words accepted -> immediate IDLE, core_reset=1; a following load_req with 1 word (last) -> DONE, words_loaded=1.
- With INST_LOADER_CHECKSUM_EN: words 5, 3 plus checksum 6 -> DONE; checksum 7 -> ERR; checksum word never appears on mem_we.
